// File: rtl/con_window_feed.sv
// ----------------------------------------------------------------------------
// con_window_feed
//
// Streaming KxK window generator feeding the image side of the convolution
// core. Pixels arrive one per cycle in raster order. The previous K-1 image
// rows are kept in a line-buffer shift chain. Every stride-1 "valid" window
// (one that never crosses the image edge) is emitted as a packed bus with a
// single-cycle strobe.
//
// Window packing: slice i of `ima` holds the window pixel at row i/K and
// column i%K. Row 0 is the oldest (top) row and column 0 is the leftmost
// column, so slice NUM-1 is the most recently accepted pixel.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   pix_in      IMA-bit unsigned pixel
//   pix_valid   pix_in is offered this cycle
//   sof         start of frame, qualified by pix_valid, marks pixel (0,0)
//   ima         packed KxK window, held until the next enable
//   enable      one-cycle strobe, ima carries a new window
//   busy        frame in progress
//   frame_done  one-cycle pulse together with the final window of a frame
// ----------------------------------------------------------------------------
module con_window_feed #(
    parameter int IMA = 8,
    parameter int K   = 7,
    parameter int W   = 28,
    parameter int H   = 28
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IMA-1:0]     pix_in,
    input  logic               pix_valid,
    input  logic               sof,
    output logic [IMA*K*K-1:0] ima,
    output logic               enable,
    output logic               busy,
    output logic               frame_done
);

    localparam int NUM = K * K;
    localparam int CW  = (W > 1) ? $clog2(W) : 1;
    localparam int RW  = (H > 1) ? $clog2(H) : 1;
    // One flat shift chain holds all K-1 previous rows; element j is the
    // pixel accepted j+1 acceptances ago.
    localparam int LB  = (K - 1) * W;

    localparam logic [CW-1:0] COL_LAST  = CW'(W - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(H - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t          state;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;

    logic            accept;
    logic [CW-1:0]   col_eff;
    logic [RW-1:0]   row_eff;
    logic [CW-1:0]   col_nxt;
    logic [RW-1:0]   row_nxt;
    logic            completes;
    logic            at_last;

    logic [IMA-1:0]  lb [LB];
    logic [IMA-1:0]  win [NUM];
    logic [IMA-1:0]  win_nxt [NUM];
    logic [IMA-1:0]  tap [K];
    logic [IMA*NUM-1:0] win_flat;

    // Acceptance and the effective position of the incoming pixel. A pixel
    // with sof is always taken as (0,0), also when it aborts a running frame,
    // so the row gating restarts and stale line-buffer rows never reach a
    // window. Without sof, pixels count only while a frame is active.
    always_comb begin
        accept  = 1'b0;
        col_eff = '0;
        row_eff = '0;
        if (pix_valid) begin
            if (sof) begin
                accept = 1'b1;
            end else if (state == ACTIVE) begin
                accept  = 1'b1;
                col_eff = col;
                row_eff = row;
            end
        end

        completes = accept && (row_eff >= ROW_FIRST) && (col_eff >= COL_FIRST);
        at_last   = accept && (row_eff == ROW_LAST) && (col_eff == COL_LAST);

        // Raster advance; the row increment at ROW_LAST only happens together
        // with at_last, where the counters are cleared instead.
        if (col_eff == COL_LAST) begin
            col_nxt = '0;
            row_nxt = row_eff + 1'b1;
        end else begin
            col_nxt = col_eff + 1'b1;
            row_nxt = row_eff;
        end
    end

    // New right-hand window column: rows 0..K-2 come from the line chain at
    // the same column of the K-1..1 previous rows, the bottom row is the
    // pixel arriving now. The rest of the window slides one column left.
    always_comb begin
        for (int r = 0; r < K - 1; r++) begin
            tap[r] = lb[(K - 1 - r) * W - 1];
        end
        tap[K-1] = pix_in;

        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                win_nxt[r*K + c] = win[r*K + c + 1];
            end
            win_nxt[r*K + K - 1] = tap[r];
        end

        for (int i = 0; i < NUM; i++) begin
            win_flat[i*IMA +: IMA] = win_nxt[i];
        end
    end

    // Pixel storage. Contents are not reset: nothing stale is emitted
    // because emission is gated by the counters of the current frame.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb[0] <= pix_in;
            for (int j = 1; j < LB; j++) begin
                lb[j] <= lb[j-1];
            end
            for (int i = 0; i < NUM; i++) begin
                win[i] <= win_nxt[i];
            end
        end
    end

    // Frame FSM, raster counters and registered outputs. busy stays high for
    // the cycle after the final pixel so it covers the last enable and the
    // frame_done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            ima        <= '0;
            enable     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            enable     <= completes;
            frame_done <= at_last;
            busy       <= accept || (state == ACTIVE);

            if (completes) begin
                ima <= win_flat;
            end

            if (accept) begin
                if (at_last) begin
                    state <= IDLE;
                    col   <= '0;
                    row   <= '0;
                end else begin
                    state <= ACTIVE;
                    col   <= col_nxt;
                    row   <= row_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_con_window_feed.sv
// ----------------------------------------------------------------------------
// tb_con_window_feed
//
// Self-checking bench for con_window_feed. Expected windows are computed
// directly from a stored image: every pixel (r,c) with r,c >= K-1 yields the
// KxK block whose bottom-right corner is (r,c).
// ----------------------------------------------------------------------------
module tb_con_window_feed;

    localparam int IMA = 8;
    localparam int K   = 7;
    localparam int W   = 28;
    localparam int H   = 28;
    localparam int NUM = K * K;
    localparam int FIRST_IDX = (K - 1) * W + (K - 1);
    localparam int NWIN = (H - K + 1) * (W - K + 1);

    logic               clk;
    logic               rst_n;
    logic [IMA-1:0]     pix_in;
    logic               pix_valid;
    logic               sof;
    logic [IMA*NUM-1:0] ima;
    logic               enable;
    logic               busy;
    logic               frame_done;

    logic [IMA-1:0]     s_pix;
    logic               s_valid;
    logic               s_sof;
    logic [IMA*NUM-1:0] s_ima;
    logic               s_enable;
    logic               s_busy;
    logic               s_frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [IMA-1:0]     img [H][W];
    logic [IMA*NUM-1:0] exp_q [$];
    logic [IMA*NUM-1:0] obs_q [$];
    int                 obs_idx [$];

    int   done_cnt;
    int   done_at;
    int   done_no_en;
    int   stall_en;
    int   early_en;
    int   busy_seen;
    int   s_en_cnt;
    int   last_idx;
    logic valid_at_edge;

    con_window_feed #(.IMA(IMA), .K(K), .W(W), .H(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .sof        (sof),
        .ima        (ima),
        .enable     (enable),
        .busy       (busy),
        .frame_done (frame_done)
    );

    con_window_feed #(.IMA(IMA), .K(K), .W(K), .H(K)) u_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_in     (s_pix),
        .pix_valid  (s_valid),
        .sof        (s_sof),
        .ima        (s_ima),
        .enable     (s_enable),
        .busy       (s_busy),
        .frame_done (s_frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remember what the DUT saw at each edge: the pixel index within the
    // current frame and whether a pixel was offered at all.
    always @(posedge clk) begin
        valid_at_edge = pix_valid;
        if (pix_valid) last_idx = sof ? 0 : last_idx + 1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (enable) begin
                obs_q.push_back(ima);
                obs_idx.push_back(last_idx);
                if (!valid_at_edge) stall_en++;
                if (last_idx < FIRST_IDX) early_en++;
            end
            if (frame_done) begin
                done_cnt++;
                done_at = obs_q.size();
                if (!enable) done_no_en++;
            end
            if (busy) busy_seen++;
            if (s_enable) s_en_cnt++;
        end
    end

    task automatic clear_obs();
        obs_q.delete();
        obs_idx.delete();
        exp_q.delete();
        done_cnt   = 0;
        done_at    = -1;
        done_no_en = 0;
        stall_en   = 0;
        early_en   = 0;
        busy_seen  = 0;
    endtask

    task automatic fill_pattern();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = IMA'((r * W + c) & 255);
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = IMA'($urandom);
    endtask

    // Append the windows completed by the first npix pixels of img.
    task automatic build_expected(input int npix);
        logic [IMA*NUM-1:0] w;
        for (int p = 0; p < npix; p++) begin
            int r, c;
            r = p / W;
            c = p % W;
            if (r >= K - 1 && c >= K - 1) begin
                for (int i = 0; i < NUM; i++)
                    w[i*IMA +: IMA] = img[r - K + 1 + i / K][c - K + 1 + i % K];
                exp_q.push_back(w);
            end
        end
    endtask

    function automatic int count_mismatch();
        int n = 0;
        int m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < m; i++)
            if (obs_q[i] !== exp_q[i]) n++;
        return n;
    endfunction

    // stall_mode: 0 none, 1 one idle cycle before every pixel, 2 random 0..2
    task automatic drive_frame(input int npix, input int stall_mode);
        for (int p = 0; p < npix; p++) begin
            int ns;
            ns = (stall_mode == 1) ? 1 : (stall_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            repeat (ns) begin
                @(posedge clk); #1;
                pix_valid = 1'b0;
                sof       = 1'b0;
                pix_in    = IMA'($urandom);
            end
            @(posedge clk); #1;
            pix_valid = 1'b1;
            sof       = (p == 0);
            pix_in    = img[p / W][p % W];
        end
    endtask

    task automatic finish_frame();
        @(posedge clk); #1;
        pix_valid = 1'b0;
        sof       = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (ima !== '0) $display("[TB] FAIL reset_ima: got %0h, expected 0", ima);
        else n_pass++;
        n_checks++;
        if ({enable, busy, frame_done} !== 3'b000)
            $display("[TB] FAIL reset_ctrl: got %b, expected 000", {enable, busy, frame_done});
        else n_pass++;

        rst_n = 1'b1;
        fill_pattern();
        drive_frame(180, 0);
        @(posedge clk); #1;
        pix_valid = 1'b0;
        sof       = 1'b0;
        n_checks++;
        if ({enable, busy} !== 2'b11)
            $display("[TB] FAIL pre_reset_active: got %b, expected 11", {enable, busy});
        else n_pass++;

        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (ima !== '0) $display("[TB] FAIL async_reset_ima: got %0h, expected 0", ima);
        else n_pass++;
        n_checks++;
        if ({enable, busy, frame_done} !== 3'b000)
            $display("[TB] FAIL async_reset_ctrl: got %b, expected 000", {enable, busy, frame_done});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        clear_obs();
    endtask

    task automatic test_full_frame();
        logic [IMA*NUM-1:0] w0, wl;
        clear_obs();
        fill_pattern();
        build_expected(W * H);
        drive_frame(W * H, 0);
        @(posedge clk); #1;
        pix_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, enable, frame_done} !== 3'b111)
            $display("[TB] FAIL last_cycle: got %b, expected 111", {busy, enable, frame_done});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({busy, enable, frame_done} !== 3'b000)
            $display("[TB] FAIL after_last: got %b, expected 000", {busy, enable, frame_done});
        else n_pass++;
        repeat (2) @(negedge clk);

        n_checks++;
        if (obs_q.size() !== NWIN) $display("[TB] FAIL full_count: got %0d, expected %0d", obs_q.size(), NWIN);
        else n_pass++;
        n_checks++;
        if (count_mismatch() !== 0) $display("[TB] FAIL full_windows: got %0d bad windows, expected 0", count_mismatch());
        else n_pass++;

        w0 = (obs_q.size() > 0) ? obs_q[0] : '0;
        wl = (obs_q.size() > 0) ? obs_q[obs_q.size() - 1] : '0;
        n_checks++;
        if (obs_idx.size() == 0 || obs_idx[0] !== 174)
            $display("[TB] FAIL first_pulse_idx: got %0d, expected 174", (obs_idx.size() > 0) ? obs_idx[0] : -1);
        else n_pass++;
        n_checks++;
        if ({w0[0*8 +: 8], w0[6*8 +: 8], w0[42*8 +: 8], w0[48*8 +: 8]} !== {8'd0, 8'd6, 8'd168, 8'd174})
            $display("[TB] FAIL first_window: got %0d %0d %0d %0d, expected 0 6 168 174",
                     w0[0 +: 8], w0[48 +: 8], w0[336 +: 8], w0[384 +: 8]);
        else n_pass++;
        n_checks++;
        if (wl[48*8 +: 8] !== 8'd15) $display("[TB] FAIL last_window: got %0d, expected 15", wl[384 +: 8]);
        else n_pass++;
        n_checks++;
        if ({done_cnt, done_at, done_no_en} !== {32'd1, NWIN, 32'd0})
            $display("[TB] FAIL full_done: got cnt %0d at %0d, expected cnt 1 at %0d", done_cnt, done_at, NWIN);
        else n_pass++;
    endtask

    task automatic test_stalls();
        for (int mode = 1; mode <= 2; mode++) begin
            clear_obs();
            if (mode == 1) fill_pattern(); else fill_random();
            build_expected(W * H);
            drive_frame(W * H, mode);
            finish_frame();
            n_checks++;
            if (obs_q.size() !== NWIN) $display("[TB] FAIL stall_count m%0d: got %0d, expected %0d", mode, obs_q.size(), NWIN);
            else n_pass++;
            n_checks++;
            if (count_mismatch() !== 0) $display("[TB] FAIL stall_windows m%0d: got %0d bad, expected 0", mode, count_mismatch());
            else n_pass++;
            n_checks++;
            if (stall_en !== 0) $display("[TB] FAIL stall_enable m%0d: got %0d, expected 0", mode, stall_en);
            else n_pass++;
            n_checks++;
            if ({done_cnt, done_at} !== {32'd1, NWIN})
                $display("[TB] FAIL stall_done m%0d: got cnt %0d at %0d, expected 1 at %0d", mode, done_cnt, done_at, NWIN);
            else n_pass++;
        end
    endtask

    task automatic test_abort();
        int n_old;
        clear_obs();
        fill_random();
        build_expected(300);
        n_old = exp_q.size();
        drive_frame(300, 0);
        fill_random();
        build_expected(W * H);
        drive_frame(W * H, 0);
        finish_frame();
        n_checks++;
        if (obs_q.size() !== n_old + NWIN) $display("[TB] FAIL abort_count: got %0d, expected %0d", obs_q.size(), n_old + NWIN);
        else n_pass++;
        n_checks++;
        if (count_mismatch() !== 0) $display("[TB] FAIL abort_windows: got %0d bad, expected 0", count_mismatch());
        else n_pass++;
        n_checks++;
        if (obs_idx.size() <= n_old || obs_idx[n_old] !== FIRST_IDX)
            $display("[TB] FAIL abort_first_idx: got %0d, expected %0d", (obs_idx.size() > n_old) ? obs_idx[n_old] : -1, FIRST_IDX);
        else n_pass++;
        n_checks++;
        if (early_en !== 0) $display("[TB] FAIL abort_early: got %0d, expected 0", early_en);
        else n_pass++;
        n_checks++;
        if ({done_cnt, done_at} !== {32'd1, n_old + NWIN})
            $display("[TB] FAIL abort_done: got cnt %0d at %0d, expected 1 at %0d", done_cnt, done_at, n_old + NWIN);
        else n_pass++;
    endtask

    task automatic test_ignored();
        clear_obs();
        for (int p = 0; p < 50; p++) begin
            @(posedge clk); #1;
            pix_valid = 1'b1;
            sof       = 1'b0;
            pix_in    = IMA'($urandom);
        end
        finish_frame();
        n_checks++;
        if ({obs_q.size(), busy_seen} !== {32'd0, 32'd0})
            $display("[TB] FAIL idle_ignored: got %0d en %0d busy, expected 0 0", obs_q.size(), busy_seen);
        else n_pass++;

        fill_random();
        build_expected(W * H);
        drive_frame(W * H, 0);
        finish_frame();
        n_checks++;
        if (obs_q.size() !== NWIN || count_mismatch() !== 0)
            $display("[TB] FAIL ignored_frame: got %0d windows %0d bad, expected %0d 0", obs_q.size(), count_mismatch(), NWIN);
        else n_pass++;

        clear_obs();
        for (int p = 0; p < 40; p++) begin
            @(posedge clk); #1;
            pix_valid = 1'b1;
            sof       = 1'b0;
            pix_in    = IMA'($urandom);
        end
        finish_frame();
        n_checks++;
        if ({obs_q.size(), busy_seen, done_cnt} !== {32'd0, 32'd0, 32'd0})
            $display("[TB] FAIL post_frame_ignored: got %0d en %0d busy %0d done, expected 0 0 0",
                     obs_q.size(), busy_seen, done_cnt);
        else n_pass++;
    endtask

    task automatic test_small_geometry();
        logic [IMA*NUM-1:0] exp_w;
        s_en_cnt = 0;
        for (int i = 0; i < NUM; i++) exp_w[i*IMA +: IMA] = IMA'(i);
        for (int p = 0; p < NUM; p++) begin
            @(posedge clk); #1;
            s_valid = 1'b1;
            s_sof   = (p == 0);
            s_pix   = IMA'(p);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({s_enable, s_frame_done} !== 2'b11)
            $display("[TB] FAIL small_strobes: got %b, expected 11", {s_enable, s_frame_done});
        else n_pass++;
        n_checks++;
        if (s_ima !== exp_w) $display("[TB] FAIL small_window: got %0h, expected %0h", s_ima, exp_w);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({s_en_cnt, 31'd0, s_busy} !== {32'd1, 32'd0})
            $display("[TB] FAIL small_count: got %0d en busy %b, expected 1 en busy 0", s_en_cnt, s_busy);
        else n_pass++;
    endtask

    initial begin
        rst_n     = 1'b0;
        pix_in    = '0;
        pix_valid = 1'b0;
        sof       = 1'b0;
        s_pix     = '0;
        s_valid   = 1'b0;
        s_sof     = 1'b0;
        last_idx  = 0;
        s_en_cnt  = 0;
        clear_obs();

        test_reset();
        test_full_frame();
        test_stalls();
        test_abort();
        test_ignored();
        test_small_geometry();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/con_window_feed.md
# con_window_feed

Streaming 7x7 window generator that drives the image side of the convolution core. It accepts one 8-bit pixel per cycle in raster order, buffers the previous K-1 image rows, and emits every stride-1 "valid" KxK window as a packed bus with a one-cycle `enable` strobe, so its outputs connect directly to the core's `ima`/`enable` inputs. It also reports frame progress (`busy`, `frame_done`) to the layer controller.

## Interface
- `IMA`, 8: pixel width in bits.
- `K`, 7: window edge; `NUM` = K*K = 49 pixels per window.
- `W`, 28: image width in pixels (K ≤ W ≤ 1024).
- `H`, 28: image height in pixels (K ≤ H ≤ 1024).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pix_in`  in  IMA  pixel data, unsigned.
- `pix_valid`  in  1  `pix_in` is accepted this cycle.
- `sof`  in  1  start of frame; qualified by `pix_valid`; marks pixel (0,0).
- `ima`  out  IMA*NUM  packed window.
- `enable`  out  1  one-cycle strobe: `ima` holds a new window.
- `busy`  out  1  frame in progress.
- `frame_done`  out  1  one-cycle pulse at the end of a frame.

## Operation
- Packing: slice i of `ima` (bits [(i+1)*IMA-1 : i*IMA]) = window pixel at row r = i/K, column c = i%K.
  - r = 0 is the oldest (top) row; c = 0 is the leftmost column.
  - Slice NUM-1 is the most recently accepted pixel.
- Storage:
  - K-1 line buffers of W pixels each, as shift registers or a single-port RAM per row.
  - A KxK window register array that shifts one column left per accepted pixel.
  - The new right column is taken from the line-buffer taps (rows 0..K-2) plus `pix_in` (row K-1).
- Counters:
  - `col` counts 0..W-1; it wraps to 0 and increments `row` on an accepted pixel at col = W-1.
  - `row` counts 0..H-1.
- States:
  - IDLE: pixels without `sof` are ignored. `pix_valid & sof` accepts the pixel as (0,0), sets col = 1, row = 0, and moves to ACTIVE.
  - ACTIVE: each accepted pixel updates the buffers and counters. The accepted pixel at (H-1, W-1) returns the FSM to IDLE.
- Window emission: an accepted pixel at (row, col) with row ≥ K-1 and col ≥ K-1 completes a window. Total windows per frame = (H-K+1)*(W-K+1), which is 484 at the defaults.
- Boundary conditions:
  - `sof` in ACTIVE aborts the current frame. The pixel is taken as the new (0,0) and the counters restart. Stale line-buffer data is never emitted, because the row gating restarts.
  - `pix_valid` low: a full stall. No state changes and `enable` = 0.
  - Line wrap: windows never straddle rows, because the col ≥ K-1 gating enforces this.
- Arithmetic: counters are $clog2 wide, compared without overflow. Pixel data passes through unmodified.

## Timing
- Reset values: `ima` = 0, `enable` = 0, `busy` = 0, `frame_done` = 0. All counters are 0 and the FSM is in IDLE. Line-buffer contents need not be cleared.
- Latency: `enable` and the matching `ima` are registered one cycle after the completing pixel is accepted.
- `ima` holds its value until the next `enable`. The core samples `ima` on the `enable` cycle.
- Throughput: one window per cycle maximum. There is no backpressure, because the core accepts every cycle.
- `busy` = 1 from the cycle after the `sof` pixel is accepted through the cycle after the last pixel, then returns to 0.
- `frame_done` pulses in the same cycle as the final `enable` of the frame. It is not generated for an aborted frame.
- Asynchronous reset mid-frame: outputs clear immediately and the block returns to IDLE. The next `sof` starts a clean frame.

## Test plan
- Reset: assert `rst_n` = 0 mid-cycle. Required: `ima`, `enable`, `busy` and `frame_done` go to 0 without waiting for a clock edge.
- Full frame, defaults, `pix_in` = (row*28+col) & 0xFF, `pix_valid` held at 1. Required:
  - 484 `enable` pulses.
  - The first pulse comes one cycle after pixel index 174. In that window: slice 0 = 0, slice 6 = 6, slice 42 = 168, slice 48 = 174.
  - The last window has slice 48 = 783 & 0xFF = 15.
  - A single `frame_done` pulse coincides with the last `enable`.
- Stalls: the same frame with `pix_valid` toggling 1,0,1,0. Required:
  - Identical window contents in the same order, 484 pulses.
  - `enable` never asserts in a cycle following a `pix_valid` = 0 cycle.
- Abort: `sof` reasserted at pixel index 300, followed by a full frame. Required:
  - No `enable` between the abort and new index 174.
  - 484 windows from the new frame.
  - No `frame_done` for the aborted frame.
- Ignored input: pixels with `sof` = 0 in IDLE, and pixels after the end of the frame. Required: no `enable` and `busy` stays 0.
- Small geometry with W = H = K = 7. Required: exactly one window, emitted after pixel 48, with slice i = i, and `frame_done` pulsed in the same cycle.
